// File: rtl/serial_adder.sv
// Bit-serial adder: {c,s} = a + b + i, one bit per clock, LSB first,
// built around a single full_adder cell and a three-state controller.

module full_adder (
  input  logic a,
  input  logic b,
  input  logic i,
  output logic s,
  output logic c
);
  assign s = a ^ b ^ i;
  assign c = (a & b) | (i & (a ^ b));
endmodule

module serial_adder #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         i,
  output logic [W-1:0] s,
  output logic         c,
  output logic         busy,
  output logic         done
);
  localparam int CW = $clog2(W + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state;
  logic [W-1:0]  op_a;
  logic [W-1:0]  op_b;
  logic          carry;
  logic [CW-1:0] cnt;
  logic          fa_s;
  logic          fa_c;
  logic          last_bit;
  logic [W:0]    s_shift;

  full_adder u_fa (
    .a (op_a[0]),
    .b (op_b[0]),
    .i (carry),
    .s (fa_s),
    .c (fa_c)
  );

  assign last_bit = (cnt == CW'(W - 1));
  // New sum bit enters at the MSB; after W shifts bit 0 of the result sits at s[0].
  assign s_shift  = {fa_s, s};

  // NOTE: every register here is state, so only non-blocking assignments are used;
  // blocking ones would let later statements see this edge's updates.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      op_a  <= '0;
      op_b  <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      s     <= '0;
      c     <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            op_a  <= a;
            op_b  <= b;
            carry <= i;
            cnt   <= '0;
            state <= RUN;
            busy  <= 1'b1;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        RUN: begin
          s     <= s_shift[W:1];
          op_a  <= op_a >> 1;
          op_b  <= op_b >> 1;
          carry <= fa_c;
          cnt   <= cnt + CW'(1);
          if (last_bit) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            c     <= fa_c;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder (W=8): vector table plus hand-written
// sequences for reset, ignored start, back-to-back and mid-run reset.

module tb_serial_adder;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         i;
  logic [W-1:0] s;
  logic         c;
  logic         busy;
  logic         done;

  serial_adder #(.W(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .i     (i),
    .s     (s),
    .c     (c),
    .busy  (busy),
    .done  (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       i;
    logic [7:0] s;
    logic       c;
  } vec_t;

  int         n_tests = 0;
  int         n_fail  = 0;
  logic [8:0] sb[$];   // expected {c, s}, pushed at launch, popped at done

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Called at the negedge where start was driven; returns at the negedge where done is seen.
  task automatic wait_done(input string name, output int lat, output int busy_cnt);
    lat      = -1;
    busy_cnt = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (k == 0) start = 1'b0;
      if (done) begin
        lat = k;
        break;
      end
      if (busy) busy_cnt++;
    end
    if (lat < 0) check({name, " timeout"}, 32'd0, 32'd1);
  endtask

  task automatic check_result(input string name);
    logic [8:0] e;
    if (sb.size() == 0) begin
      check({name, " scoreboard empty"}, 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      check({name, " s"}, 32'(s), 32'(e[7:0]));
      check({name, " c"}, 32'(c), 32'(e[8]));
    end
  endtask

  task automatic launch(input logic [7:0] ta, input logic [7:0] tb_v, input logic ti,
                        input logic [7:0] es, input logic ec);
    start = 1'b1;
    a     = ta;
    b     = tb_v;
    i     = ti;
    sb.push_back({ec, es});
  endtask

  vec_t vecs[8];

  initial begin
    int lat, bc, pulses, at;
    vecs[0] = '{8'h35, 8'h4A, 1'b0, 8'h7F, 1'b0};
    vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
    vecs[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
    vecs[3] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
    vecs[4] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0};
    vecs[5] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
    vecs[6] = '{8'hAA, 8'h55, 1'b1, 8'h00, 1'b1};
    vecs[7] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0};

    // Reset with start held high for two edges.
    rst_n = 1'b0;
    start = 1'b1;
    a     = 8'hFF;
    b     = 8'hFF;
    i     = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      check($sformatf("reset edge%0d outputs", k + 1), 32'({s, c, busy, done}), 32'd0);
    end
    rst_n = 1'b1;
    start = 1'b0;
    @(negedge clk);
    check("idle no start busy", 32'(busy), 32'd0);
    check("idle no start done", 32'(done), 32'd0);

    // Table-driven additions.
    foreach (vecs[n]) begin
      launch(vecs[n].a, vecs[n].b, vecs[n].i, vecs[n].s, vecs[n].c);
      wait_done($sformatf("vec%0d", n), lat, bc);
      check($sformatf("vec%0d latency", n), 32'(lat), 32'd8);
      check($sformatf("vec%0d busy cycles", n), 32'(bc), 32'd8);
      check_result($sformatf("vec%0d", n));
      @(negedge clk);
      check($sformatf("vec%0d single done", n), 32'({busy, done}), 32'd0);
      check($sformatf("vec%0d s held", n), 32'(s), 32'(vecs[n].s));
    end

    // Operands and start changed mid-run must be ignored.
    launch(8'h10, 8'h20, 1'b0, 8'h30, 1'b0);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    start = 1'b1;
    a     = 8'hFF;
    b     = 8'hFF;
    i     = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    pulses = 0;
    at     = -1;
    for (int k = 4; k < 20; k++) begin
      @(negedge clk);
      if (done) begin
        pulses++;
        if (at < 0) begin
          at = k;
          check_result("ignore");
        end
      end
    end
    check("ignore done pulses", 32'(pulses), 32'd1);
    check("ignore done sample", 32'(at), 32'd8);

    // Back-to-back: start held in the DONE cycle.
    launch(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
    wait_done("b2b first", lat, bc);
    check("b2b first latency", 32'(lat), 32'd8);
    check_result("b2b first");
    launch(8'h01, 8'h02, 1'b1, 8'h04, 1'b0);
    wait_done("b2b second", lat, bc);
    check("b2b second latency", 32'(lat), 32'd8);
    check("b2b no idle busy", 32'(bc), 32'd8);
    check_result("b2b second");
    @(negedge clk);

    // Reset at edge 4 of a run: discarded, no done pulse.
    start = 1'b1;
    a     = 8'h35;
    b     = 8'h4A;
    i     = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst outputs", 32'({s, c, busy, done}), 32'd0);
    rst_n  = 1'b1;
    pulses = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (done) pulses++;
    end
    check("midrst no done", 32'(pulses), 32'd0);
    launch(8'h80, 8'h80, 1'b0, 8'h00, 1'b1);
    wait_done("post reset", lat, bc);
    check("post reset latency", 32'(lat), 32'd8);
    check_result("post reset");

    check("scoreboard drained", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 Parameter W, default 8, SHALL set the operand and sum width in bits; legal range W >= 1.
REQ-002 clk  input  1  SHALL be the single clock; all state updates occur on its rising edge.
REQ-003 rst_n  input  1  SHALL be the reset: synchronous, active-low, sampled on the rising edge of clk.
REQ-004 start  input  1  SHALL be the request to begin an addition; sampled only in IDLE or DONE.
REQ-005 a  input  W  SHALL be operand A, captured when start is accepted.
REQ-006 b  input  W  SHALL be operand B, captured when start is accepted.
REQ-007 i  input  1  SHALL be the carry-in, captured when start is accepted.
REQ-008 s  output  W  SHALL be the sum register.
REQ-009 c  output  1  SHALL be the carry-out register.
REQ-010 busy  output  1  SHALL be high exactly while the state is RUN.
REQ-011 done  output  1  SHALL be high exactly while the state is DONE.

Function
REQ-012 The block SHALL compute {c,s} = a + b + i bit-serially, LSB first, one bit per clock.
REQ-013 Each bit SHALL be computed by one full_adder instance (ports a, b, i, s, c).
- Its i input SHALL be the internal carry register.
REQ-014 The FSM SHALL have three states: IDLE, RUN and DONE.
REQ-015 IDLE with start=1 SHALL capture a, b and i at the edge, clear the bit counter and enter RUN.
REQ-016 IDLE with start=0 SHALL remain in IDLE.
REQ-017 In RUN, each edge SHALL:
- shift the full_adder sum bit into the MSB of the sum shift register;
- shift both operand registers right by one;
- load the carry register with the full_adder carry;
- increment the bit counter.
REQ-018 RUN SHALL last exactly W edges, then enter DONE with s and c valid.
- Latency: start accepted at edge 0, done high in the cycle after edge W.
REQ-019 done SHALL be high for exactly one cycle per accepted start.
REQ-020 DONE with start=1 SHALL accept new operands and enter RUN directly (back-to-back, no IDLE cycle).
REQ-021 DONE with start=0 SHALL enter IDLE.
REQ-022 start, a, b and i SHALL be ignored in RUN.
- Operand changes during RUN SHALL NOT affect the result in progress.
REQ-023 s and c SHALL hold the last completed result from DONE until the next start is accepted.
REQ-024 While RUN is in progress, s and c SHALL NOT be interpreted by consumers; only done qualifies them.
REQ-025 The bit counter SHALL be wide enough to count W without wrap-around (ceil(log2(W+1)) bits).
REQ-026 For W=1, RUN SHALL last one edge, with the same latency rule as REQ-018.

Reset
REQ-027 rst_n=0 at a rising edge SHALL force IDLE and clear all internal state:
- s=0, c=0, busy=0, done=0;
- operand, carry and counter registers = 0.
REQ-028 Reset SHALL take priority over start, in any state, including mid-RUN.
- An interrupted addition SHALL be discarded, with no done pulse.
REQ-029 The first start accepted after rst_n returns high SHALL behave exactly as from power-up IDLE.

Verification (W=8)
REQ-030 Reset: rst_n=0 for 2 edges, with start=1 held -> s=8'h00, c=0, busy=0, done=0 throughout.
REQ-031 Basic add: a=8'h35, b=8'h4A, i=0, start pulsed at edge 0:
- busy=1 for edges 1-8;
- done=1 after edge 8 with s=8'h7F, c=0.
REQ-032 Carry chain:
- a=8'hFF, b=8'h01, i=0 -> s=8'h00, c=1;
- a=8'hFF, b=8'hFF, i=1 -> s=8'hFF, c=1.
REQ-033 Ignore during RUN: start a=8'h10, b=8'h20, i=0; at edge 3 drive start=1, a=8'hFF, b=8'hFF:
- result SHALL be s=8'h30, c=0;
- exactly one done pulse.
REQ-034 Back-to-back: start held high in the DONE cycle with a=8'h01, b=8'h02, i=1:
- no IDLE cycle;
- done again 8 edges later with s=8'h04, c=0.
REQ-035 Mid-operation reset: rst_n=0 at edge 4 of RUN:
- outputs cleared, no done pulse;
- next start with a=8'h80, b=8'h80, i=0 -> s=8'h00, c=1.
